// File: rtl/pc_unit_if.sv
// Bundles the control, target and status signals of the program-counter unit.
// Timing depends on the attached unit; for pc_unit, PC/EPC/RAS update on the commit edge.
// No handshake is used: the datapath asserts PCWrite when it wants a commit.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  // Controls and targets from the datapath
  logic             PCWrite;
  logic [2:0]       PCSrc;
  logic [15:0]      BrOffset;
  logic [25:0]      JTarget;
  logic [WIDTH-1:0] RegTarget;
  logic             RasPush;
  logic             Exc;

  // State and status reported back by the unit
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PC_plus4;
  logic [WIDTH-1:0] EPC;
  logic             ras_empty;
  logic             ras_full;
  logic             addr_err;

  modport master (
    output PCWrite, PCSrc, BrOffset, JTarget, RegTarget, RasPush, Exc,
    input  PC, PC_plus4, EPC, ras_empty, ras_full, addr_err
  );

  modport slave (
    input  PCWrite, PCSrc, BrOffset, JTarget, RegTarget, RasPush, Exc,
    output PC, PC_plus4, EPC, ras_empty, ras_full, addr_err
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter for the multi-cycle MIPS32 datapath, with EPC capture and a circular RAS.
// Latency: one cycle; PC, EPC and RAS change on the same edge that commits. PC_plus4 is combinational.
// No backpressure: a commit is requested with PCWrite and always taken unless Exc or a misaligned target traps.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'('h80),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic      CLK,
  input  logic      Reset,
  pc_unit_if.slave  bus
);

  // Pointer indexes the next free RAS slot; the count needs one extra bit to reach RAS_DEPTH.
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [2:0] SRC_SEQ  = 3'd0;
  localparam logic [2:0] SRC_BR   = 3'd1;
  localparam logic [2:0] SRC_JMP  = 3'd2;
  localparam logic [2:0] SRC_REG  = 3'd3;
  localparam logic [2:0] SRC_POP  = 3'd4;
  localparam logic [2:0] SRC_ERET = 3'd5;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic             addr_err_q;
  logic [PW-1:0]    ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [WIDTH-1:0] plus4;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] jmp_tgt;
  logic [WIDTH-1:0] pop_tgt;
  logic [WIDTH-1:0] target;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    wr_idx;
  logic             empty;
  logic             full;
  logic             commit;
  logic             misaligned;
  logic             take;
  logic             do_pop;
  logic             do_push;

  assign plus4   = pc_q + WIDTH'(4);
  assign top_idx = ptr_q - PW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(RAS_DEPTH));

  // Branch offset is a signed word count, so sign-extend then scale by four.
  assign br_tgt  = plus4 + {{(WIDTH-18){bus.BrOffset[15]}}, bus.BrOffset, 2'b00};

  // Popping an empty stack falls back to the reset vector rather than stale contents.
  assign pop_tgt = empty ? RESET_VECTOR : ras_mem[top_idx];

  // Jump keeps the upper bits of PC+4 (region above bit 27) and replaces the low 28 bits.
  always_comb begin
    jmp_tgt       = plus4;
    jmp_tgt[27:0] = {bus.JTarget, 2'b00};
  end

  // Next-PC source select; reserved encodings behave as sequential.
  always_comb begin
    target = plus4;
    case (bus.PCSrc)
      SRC_SEQ:  target = plus4;
      SRC_BR:   target = br_tgt;
      SRC_JMP:  target = jmp_tgt;
      SRC_REG:  target = bus.RegTarget;
      SRC_POP:  target = pop_tgt;
      SRC_ERET: target = epc_q;
      default:  target = plus4;
    endcase
  end

  // An exception request suppresses the commit entirely, including any RAS effect.
  assign commit     = bus.PCWrite & ~bus.Exc;
  assign misaligned = commit & (target[1:0] != 2'b00);
  assign take       = commit & ~misaligned;
  assign do_pop     = take & (bus.PCSrc == SRC_POP) & ~empty;
  assign do_push    = take & bus.RasPush;

  // Push-with-pop overwrites the current top in place; otherwise a push fills the free slot.
  assign wr_idx = (do_push && do_pop) ? top_idx : ptr_q;

  // PC, EPC and the address-error pulse; exceptions and misaligned traps both vector to EXC_VECTOR.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= 1'b0;
      if (bus.Exc) begin
        epc_q <= pc_q;
        pc_q  <= EXC_VECTOR;
      end else if (misaligned) begin
        epc_q      <= pc_q;
        pc_q       <= EXC_VECTOR;
        addr_err_q <= 1'b1;
      end else if (take) begin
        pc_q <= target;
      end
    end
  end

  // RAS pointer and occupancy; a full stack keeps wrapping and overwrites its oldest entry.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (do_push && !do_pop) begin
      ptr_q <= ptr_q + PW'(1);
      if (!full) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else if (do_pop && !do_push) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // RAS storage carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (!Reset && do_push) begin
      ras_mem[wr_idx] <= plus4;
    end
  end

  assign bus.PC        = pc_q;
  assign bus.PC_plus4  = plus4;
  assign bus.EPC       = epc_q;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver issues directed then random commands and queues
// the reference model's expected post-edge state; a monitor pops and compares after each edge.
module tb_pc_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus4;
    logic [31:0] epc;
    logic        empty;
    logic        full;
    logic        aerr;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  // Reference model state: the RAS is a plain list, newest entry last.
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_aerr;
  logic [31:0] m_ras[$];

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH(32),
    .RESET_VECTOR(32'h0),
    .EXC_VECTOR(32'h80),
    .RAS_DEPTH(4)
  ) dut (
    .CLK(clk),
    .Reset(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the unit presents fresh state after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",        bus.PC,                 e.pc);
        chk("pc_plus4",  bus.PC_plus4,           e.plus4);
        chk("epc",       bus.EPC,                e.epc);
        chk("ras_empty", {31'b0, bus.ras_empty}, {31'b0, e.empty});
        chk("ras_full",  {31'b0, bus.ras_full},  {31'b0, e.full});
        chk("addr_err",  {31'b0, bus.addr_err},  {31'b0, e.aerr});
      end
    end
  end

  // Drive one cycle of inputs, advance the model across the coming edge, queue its result.
  task automatic step(input logic r, input logic w, input logic [2:0] src,
                      input logic [15:0] off, input logic [25:0] jt,
                      input logic [31:0] rt, input logic push, input logic exc);
    logic [31:0] p4;
    logic [31:0] tgt;
    exp_t        e;
    rst           = r;
    bus.PCWrite   = w;
    bus.PCSrc     = src;
    bus.BrOffset  = off;
    bus.JTarget   = jt;
    bus.RegTarget = rt;
    bus.RasPush   = push;
    bus.Exc       = exc;

    p4 = m_pc + 32'd4;
    if (r) begin
      m_pc   = 32'h0;
      m_epc  = 32'h0;
      m_aerr = 1'b0;
      m_ras.delete();
    end else if (exc) begin
      m_epc  = m_pc;
      m_pc   = 32'h80;
      m_aerr = 1'b0;
    end else if (w) begin
      case (src)
        3'd1:    tgt = p4 + (32'(signed'(off)) * 4);
        3'd2:    tgt = {p4[31:28], jt, 2'b00};
        3'd3:    tgt = rt;
        3'd4:    tgt = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
        3'd5:    tgt = m_epc;
        default: tgt = p4;
      endcase
      if (tgt[1:0] != 2'b00) begin
        m_epc  = m_pc;
        m_pc   = 32'h80;
        m_aerr = 1'b1;
      end else begin
        if (src == 3'd4 && push && m_ras.size() > 0) begin
          m_ras[m_ras.size()-1] = p4;
        end else begin
          if (src == 3'd4 && m_ras.size() > 0) void'(m_ras.pop_back());
          if (push) begin
            m_ras.push_back(p4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
          end
        end
        m_pc   = tgt;
        m_aerr = 1'b0;
      end
    end else begin
      m_aerr = 1'b0;
    end

    e.pc    = m_pc;
    e.plus4 = m_pc + 32'd4;
    e.epc   = m_epc;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == 4);
    e.aerr  = m_aerr;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Shorthands for common commands.
  task automatic go_reg(input logic [31:0] a, input logic push);
    step(1'b0, 1'b1, 3'd3, 16'h0, 26'h0, a, push, 1'b0);
  endtask

  task automatic go_src(input logic [2:0] src, input logic push);
    step(1'b0, 1'b1, src, 16'h0, 26'h0, 32'h0, push, 1'b0);
  endtask

  initial begin
    logic [31:0] rt;
    checks = 0;
    errors = 0;
    m_pc   = 32'h0;
    m_epc  = 32'h0;
    m_aerr = 1'b0;

    // Reset then sequential fetch.
    repeat (2) step(1'b1, 1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) go_src(3'd0, 1'b0);

    // Backward branch, then jump.
    go_reg(32'h100, 1'b0);
    step(1'b0, 1'b1, 3'd1, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'd2, 16'h0, 26'h0000040, 32'h0, 1'b0, 1'b0);

    // jal, pop back, then pop an empty stack.
    go_reg(32'h200, 1'b0);
    step(1'b0, 1'b1, 3'd2, 16'h0, 26'h0000300, 32'h0, 1'b1, 1'b0);
    go_src(3'd4, 1'b0);
    go_src(3'd4, 1'b0);

    // Overfill the stack, then drain it.
    step(1'b1, 1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    go_reg(32'h10, 1'b1);
    go_reg(32'h20, 1'b1);
    go_reg(32'h30, 1'b1);
    go_reg(32'h40, 1'b1);
    go_reg(32'h500, 1'b1);
    repeat (5) go_src(3'd4, 1'b0);

    // Push and pop in one commit, on a non-empty and an empty stack.
    go_reg(32'h600, 1'b1);
    go_src(3'd4, 1'b1);
    go_src(3'd4, 1'b0);
    go_src(3'd4, 1'b1);

    // Misaligned register target traps, hold a cycle, then eret.
    go_reg(32'h300, 1'b0);
    go_reg(32'h302, 1'b0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    go_src(3'd5, 1'b0);

    // Exception beats a push-commit; reset beats an exception.
    go_reg(32'h400, 1'b0);
    step(1'b0, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rt = $urandom;
      if ($urandom_range(0, 4) != 0) rt[1:0] = 2'b00;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
           3'($urandom_range(0, 7)), 16'($urandom), 26'($urandom), rt,
           $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
    end

    bus.PCWrite = 1'b0;
    bus.Exc     = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the multi-cycle MIPS32 datapath.
- Holds the PC and computes the next-PC from one of six sources: sequential, branch, jump, register, return-address-stack pop, or eret.
- Takes exceptions, including misaligned targets, with EPC capture.
- Maintains a small circular return-address stack (RAS) for jal/jr $ra.

Parameters:
WIDTH, 32, PC/address width; legal range 28..64.
RESET_VECTOR, 32'h0000_0000, PC value after reset.
EXC_VECTOR, 32'h0000_0080, PC value loaded on exception.
RAS_DEPTH, 4, RAS entries; power of two, 2..16.

Ports:
CLK  in  1  clock, rising edge.
Reset  in  1  synchronous, active-high.
PCWrite  in  1  commit next-PC this cycle.
PCSrc  in  3  0=PC+4, 1=branch, 2=jump, 3=register, 4=RAS pop, 5=eret; 6,7 reserved, treated as 0.
BrOffset  in  16  branch immediate, word offset.
JTarget  in  26  jump instruction index.
RegTarget  in  WIDTH  jr/jalr register value.
RasPush  in  1  push PC+4 (jal/jalr); honoured only when PCWrite=1.
Exc  in  1  external exception request.
PC  out  WIDTH  current PC.
PC_plus4  out  WIDTH  PC+4, combinational.
EPC  out  WIDTH  exception PC.
ras_empty  out  1  RAS holds 0 entries.
ras_full  out  1  RAS holds RAS_DEPTH entries.
addr_err  out  1  one-cycle pulse: misaligned target trapped.

Behaviour:
- Reset (highest priority):
  - PC=RESET_VECTOR, EPC=0, RAS count=0, RAS pointer=0, addr_err=0.
  - RAS entry contents are don't-care.
- All arithmetic is modulo 2^WIDTH. PC+4 wraps at all-ones.
- Target computation, from the current PC:
  - branch = PC+4 + (sign_extend(BrOffset) << 2).
  - jump = {PC_plus4[WIDTH-1:28], JTarget, 2'b00}.
  - register = RegTarget.
  - RAS pop = top entry, or RESET_VECTOR if the RAS is empty.
  - eret = EPC.
- Priority per cycle (non-reset): Exc > misaligned target > PCWrite > hold.
- Exc=1: EPC<=PC, PC<=EXC_VECTOR. The RAS is untouched. PCWrite and RasPush are ignored.
- PCWrite=1, Exc=0, selected target[1:0]!=0:
  - EPC<=PC, PC<=EXC_VECTOR.
  - addr_err=1 for exactly the next cycle.
  - RAS is not modified.
- PCWrite=1, target aligned: PC<=target, updated on the same edge (1-cycle latency).
- PCWrite=0, Exc=0: PC, EPC and RAS hold.
- RAS pop (PCSrc=4, PCWrite=1, committed):
  - Non-empty: pointer decrements, count decrements.
  - Empty: no state change, PC<=RESET_VECTOR.
- RAS push (RasPush=1, committed):
  - Writes PC+4 at the pointer; pointer increments mod RAS_DEPTH; count saturates at RAS_DEPTH.
  - When full, the oldest entry is silently overwritten.
- Push and pop in the same commit: the top entry is replaced by PC+4; pointer and count are unchanged. When empty, this behaves as a plain push.
- eret does not alter EPC.
- Exc asserted during a cycle that would have pushed or popped: no RAS change.
- Reset asserted mid-sequence overrides everything on that edge.

Test Plan:
- Reset=1 for 2 cycles, then PCWrite=1, PCSrc=0 for 3 cycles -> PC = 0x0, then 0x4, 0x8, 0xC. ras_empty=1 throughout.
- PC=0x100, PCSrc=1, BrOffset=16'hFFFE -> PC=0xFC. Then PCSrc=2, JTarget=26'h0000040 -> PC=0x100.
- PC=0x200, RasPush=1, PCSrc=2 (jal) -> RAS top=0x204. Later PCSrc=4 -> PC=0x204, ras_empty=1. A further pop -> PC=RESET_VECTOR (0x0).
- RAS_DEPTH=4: five pushes from PCs 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_full=1. Four pops return 0x44, 0x34, 0x24, 0x14, then ras_empty=1.
- PC=0x300, PCSrc=3, RegTarget=0x302 -> PC=0x80, EPC=0x300, addr_err high exactly one cycle. Then PCSrc=5 -> PC=0x300.
- Exc=1 together with PCWrite=1, RasPush=1 at PC=0x400 -> PC=0x80, EPC=0x400, RAS count unchanged. Reset=1 with Exc=1 -> PC=0x0, EPC=0.
